// File: rtl/apb_tx_pkg.sv
// Shared definitions for the APB requester: FSM state encoding and the
// timeout-counter width helper.
package apb_tx_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } apb_state_t;

   // A zero TIMEOUT still needs a 1-bit counter so the vector stays legal.
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/apb_tx_if.sv
// APB bus bundle between one requester (master) and one completer (slave).
interface apb_tx_if #(
   parameter int DATA_BW = 8,
   parameter int ADDR_BW = 8
);
   logic               psel;
   logic               penable;
   logic               pwrite;
   logic [ADDR_BW-1:0] paddr;
   logic [DATA_BW-1:0] pwdata;
   logic [DATA_BW-1:0] prdata;
   logic               pready;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready
   );
endinterface

// File: rtl/apb_tx_timeout_cnt.sv
// Counts consecutive ACCESS wait states; expired flags the last allowed wait
// so the requester can abort on that same edge. TIMEOUT=0 never expires.
module apb_tx_timeout_cnt
   import apb_tx_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int            CW   = cnt_width(TIMEOUT);
   localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
   localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (inc && (cnt != SAT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (TIMEOUT > 0) && (cnt == LAST);

endmodule

// File: rtl/apb_tx.sv
// APB requester: one APB transfer per accepted command, one-cycle response
// pulse carrying read data or a timeout error.
module apb_tx
   import apb_tx_pkg::*;
#(
   parameter int DATA_BW = 8,
   parameter int ADDR_BW = 8,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_write,
   input  logic [ADDR_BW-1:0] cmd_addr,
   input  logic [DATA_BW-1:0] cmd_wdata,
   output logic               rsp_valid,
   output logic [DATA_BW-1:0] rsp_rdata,
   output logic               rsp_err,
   apb_tx_if.master           apb
);

   apb_state_t state, state_n;
   logic       accept;
   logic       done;
   logic       abort;
   logic       expired;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // cmd_ready follows pready combinationally so a new command can be taken
   // on the completing edge, giving one transfer every two cycles.
   always_comb begin
      state_n   = state;
      cmd_ready = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_n = SETUP;
         end
         SETUP: state_n = ACCESS;
         ACCESS: begin
            if (apb.pready) begin
               done      = 1'b1;
               cmd_ready = 1'b1;
               state_n   = cmd_valid ? SETUP : IDLE;
            end else if (expired) begin
               abort   = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign accept = cmd_valid & cmd_ready;

   // Bus and response registers: decoded from the next state so psel/penable
   // line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         apb.psel    <= 1'b0;
         apb.penable <= 1'b0;
         apb.pwrite  <= 1'b0;
         apb.paddr   <= '0;
         apb.pwdata  <= '0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_rdata   <= '0;
      end else begin
         apb.psel    <= (state_n != IDLE);
         apb.penable <= (state_n == ACCESS);
         if (accept) begin
            apb.pwrite <= cmd_write;
            apb.paddr  <= cmd_addr;
            apb.pwdata <= cmd_wdata;
         end
         rsp_valid <= done | abort;
         rsp_err   <= abort;
         rsp_rdata <= (done && !apb.pwrite) ? apb.prdata : '0;
      end
   end

   apb_tx_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (accept),
      .inc     ((state == ACCESS) && !apb.pready),
      .expired (expired)
   );

endmodule

// File: tb/tb_apb_tx.sv
// Bench: two requesters (TIMEOUT=4 and TIMEOUT=0) driven in lockstep, each
// paired with a wait-state-configurable completer memory.
module tb_apb_tx;

   localparam int DW = 8;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          cmd_valid = 1'b0;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr  = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rdy4, rdy0, rv4, rv0, re4, re0;
   logic [DW-1:0] rd4, rd0;

   int checks   = 0;
   int failures = 0;
   int wait_cfg = 0;
   int acc4, acc0;
   logic [DW-1:0] mem4 [256];
   logic [DW-1:0] mem0 [256];
   logic [DW-1:0] ref4 [256];
   logic [DW-1:0] ref0 [256];

   apb_tx_if #(.DATA_BW(DW), .ADDR_BW(AW)) bus4 ();
   apb_tx_if #(.DATA_BW(DW), .ADDR_BW(AW)) bus0 ();

   apb_tx #(.DATA_BW(DW), .ADDR_BW(AW), .TIMEOUT(4)) dut4 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy4),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rv4), .rsp_rdata(rd4), .rsp_err(re4), .apb(bus4)
   );

   apb_tx #(.DATA_BW(DW), .ADDR_BW(AW), .TIMEOUT(0)) dut0 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0), .apb(bus0)
   );

   // Completers: pready rises after wait_cfg ACCESS cycles; memory cleared on reset.
   assign bus4.pready = bus4.psel & bus4.penable & (acc4 >= wait_cfg);
   assign bus4.prdata = mem4[bus4.paddr];
   assign bus0.pready = bus0.psel & bus0.penable & (acc0 >= wait_cfg);
   assign bus0.prdata = mem0[bus0.paddr];

   always @(posedge clk) begin
      if (rst) begin
         acc4 <= 0;
         for (int k = 0; k < 256; k++) mem4[k] <= '0;
      end else if (bus4.psel && bus4.penable) begin
         if (bus4.pready) begin
            acc4 <= 0;
            if (bus4.pwrite) mem4[bus4.paddr] <= bus4.pwdata;
         end else begin
            acc4 <= acc4 + 1;
         end
      end else begin
         acc4 <= 0;
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         acc0 <= 0;
         for (int k = 0; k < 256; k++) mem0[k] <= '0;
      end else if (bus0.psel && bus0.penable) begin
         if (bus0.pready) begin
            acc0 <= 0;
            if (bus0.pwrite) mem0[bus0.paddr] <= bus0.pwdata;
         end else begin
            acc0 <= acc0 + 1;
         end
      end else begin
         acc0 <= 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_refs();
      for (int k = 0; k < 256; k++) begin
         ref4[k] = '0;
         ref0[k] = '0;
      end
   endtask

   // One command issued to both requesters from IDLE; expectations come from
   // the transfer rules: rsp at accept+3+waits, or accept+2+TIMEOUT on abort.
   task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d, input int waits);
      logic       err4;
      int         lat4, lat0;
      logic [7:0] exp4, exp0;
      err4 = (waits >= 4);
      lat4 = err4 ? 2 + 4 : 3 + waits;
      lat0 = 3 + waits;
      exp4 = (wr || err4) ? 8'h00 : ref4[a];
      exp0 = wr ? 8'h00 : ref0[a];
      if (wr && !err4) ref4[a] = d;
      if (wr) ref0[a] = d;
      wait_cfg = waits;
      chk("idle_ready4", rdy4, 1);
      chk("idle_ready0", rdy0, 1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      for (int i = 1; i <= lat0 + 1; i++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         cmd_addr  = 8'($urandom);
         cmd_wdata = 8'($urandom);
         if (i == 1) begin
            chk("setup_psel4", bus4.psel, 1);
            chk("setup_penable4", bus4.penable, 0);
            chk("setup_pwrite4", bus4.pwrite, wr);
            chk("setup_ready4", rdy4, 0);
            chk("setup_psel0", bus0.psel, 1);
         end
         if (bus4.psel) begin
            chk("paddr4_hold", bus4.paddr, a);
            if (wr) chk("pwdata4_hold", bus4.pwdata, d);
         end
         if (bus0.psel) chk("paddr0_hold", bus0.paddr, a);
         if (bus4.psel && bus4.penable) chk("ready4_vs_pready", rdy4, bus4.pready);
         if (i == lat4) begin
            chk("rsp_valid4", rv4, 1);
            chk("rsp_err4", re4, err4);
            chk("rsp_rdata4", rd4, exp4);
            chk("post_psel4", bus4.psel, 0);
         end else begin
            chk("rsp_quiet4", rv4, 0);
         end
         if (i == lat0) begin
            chk("rsp_valid0", rv0, 1);
            chk("rsp_err0", re0, 0);
            chk("rsp_rdata0", rd0, exp0);
            chk("post_psel0", bus0.psel, 0);
         end else begin
            chk("rsp_quiet0", rv0, 0);
         end
      end
      chk("end_ready4", rdy4, 1);
      chk("end_ready0", rdy0, 1);
   endtask

   initial begin
      clear_refs();
      repeat (3) @(negedge clk);
      chk("rst_psel", bus4.psel, 0);
      chk("rst_penable", bus4.penable, 0);
      chk("rst_pwrite", bus4.pwrite, 0);
      chk("rst_paddr", bus4.paddr, 0);
      chk("rst_pwdata", bus4.pwdata, 0);
      chk("rst_rsp_valid", rv4, 0);
      chk("rst_rsp_rdata", rd4, 0);
      chk("rst_rsp_err", re4, 0);
      chk("rst_psel0", bus0.psel, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_cmd_ready", rdy4, 1);

      // Single write then read with wait states
      xfer(1'b1, 8'h10, 8'hA5, 0);
      chk("mem4_10", mem4[8'h10], 8'hA5);
      xfer(1'b0, 8'h10, 8'h00, 3);

      // Back-to-back write then read with cmd_valid held
      wait_cfg = 0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h01; cmd_wdata = 8'h11;
      @(negedge clk);
      chk("b2b_setup1_psel", bus4.psel, 1);
      chk("b2b_setup1_pen", bus4.penable, 0);
      cmd_write = 1'b0; cmd_wdata = 8'h00;
      @(negedge clk);
      chk("b2b_access1_pen", bus4.penable, 1);
      chk("b2b_access1_rdy4", rdy4, 1);
      chk("b2b_access1_rdy0", rdy0, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("b2b_setup2_psel", bus4.psel, 1);
      chk("b2b_setup2_pen", bus4.penable, 0);
      chk("b2b_setup2_pwrite", bus4.pwrite, 0);
      chk("b2b_rsp1_valid", rv4, 1);
      chk("b2b_rsp1_err", re4, 0);
      chk("b2b_rsp1_rdata", rd4, 0);
      chk("b2b_rsp1_valid0", rv0, 1);
      @(negedge clk);
      chk("b2b_access2_psel", bus4.psel, 1);
      chk("b2b_access2_pen", bus4.penable, 1);
      chk("b2b_access2_quiet", rv4, 0);
      @(negedge clk);
      chk("b2b_rsp2_valid", rv4, 1);
      chk("b2b_rsp2_rdata", rd4, 8'h11);
      chk("b2b_rsp2_rdata0", rd0, 8'h11);
      chk("b2b_rsp2_psel", bus4.psel, 0);
      ref4[8'h01] = 8'h11;
      ref0[8'h01] = 8'h11;

      // Timeout: dut4 aborts, dut0 waits it out
      xfer(1'b0, 8'h10, 8'h00, 20);
      xfer(1'b1, 8'h30, 8'h99, 5);
      xfer(1'b0, 8'h30, 8'h00, 0);

      // Reset during ACCESS
      wait_cfg = 10;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 8'h77;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("rstmid_in_access", bus4.penable, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_psel", bus4.psel, 0);
      chk("rstmid_penable", bus4.penable, 0);
      chk("rstmid_rsp_valid", rv4, 0);
      chk("rstmid_psel0", bus0.psel, 0);
      chk("rstmid_rsp_valid0", rv0, 0);
      rst = 1'b0;
      clear_refs();
      @(negedge clk);
      chk("rstmid_quiet", rv4, 0);
      xfer(1'b1, 8'h20, 8'h3C, 0);
      xfer(1'b0, 8'h20, 8'h00, 0);

      // Long wait: TIMEOUT=0 never aborts
      xfer(1'b0, 8'h20, 8'h00, 100);

      // Randomized traffic
      for (int n = 0; n < 24; n++) begin
         xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
              int'($urandom_range(0, 6)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
